park_gate_sequencer: RTL and testbench

PARK_GATE_SEQUENCER -- requirements
Module: park_gate_sequencer

---
 rtl/park_pkg.sv | 20 ++
 rtl/park_gate_sequencer_debounce.sv | 55 +++++
 rtl/park_gate_sequencer.sv | 104 ++++++++++
 tb/tb_park_gate_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/park_pkg.sv
// Shared types and defaults for the parking gate sequencer.
package park_pkg;

  // Gate FSM: entry path IN_*, exit path OUT_*
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_A   = 3'd1,
    IN_AB  = 3'd2,
    IN_B   = 3'd3,
    OUT_B  = 3'd4,
    OUT_BA = 3'd5,
    OUT_A  = 3'd6
  } park_state_e;

  localparam int unsigned CAPACITY_DEF = 10;
  localparam int unsigned DEBOUNCE_DEF = 4;
  localparam int unsigned OCC_W        = 4;
  localparam int unsigned DB_CNT_W     = 8;

endpackage

// File: rtl/park_gate_sequencer_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for one beam.
module sensor_debounce
  import park_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean
);

  logic                sync1_q, sync2_q;
  logic                clean_q, clean_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous beam into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Flip clean only after DEBOUNCE consecutive mismatching samples; any match restarts the count
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == DB_CNT_W'(DEBOUNCE - 1)) begin
        clean_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  // Debouncer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/park_gate_sequencer.sv
// Two-beam parking gate: recognises entry/exit sequences, pulses the occupancy
// counter, drives the barrier and refuses entry when the lot is full.
module park_gate_sequencer
  import park_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEF,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_a,
  input  logic             sensor_b,
  input  logic [OCC_W-1:0] count,
  output logic             count_up,
  output logic             count_down,
  output logic             gate_open,
  output logic             full
);

  localparam logic [OCC_W-1:0] CAP = OCC_W'(CAPACITY);

  logic        a_db, b_db;
  logic [1:0]  ab;
  park_state_e state_q, state_d;
  logic        up_q, up_d, dn_q, dn_d, gate_q, full_q, full_d;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_a (
    .clk(clk), .rst(rst), .raw(sensor_a), .clean(a_db)
  );
  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_b (
    .clk(clk), .rst(rst), .raw(sensor_b), .clean(b_db)
  );

  assign ab     = {a_db, b_db};
  assign full_d = (count >= CAP);

  // Next-state and pulse decode from the debounced beam pair
  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Entry refused while full; a lone b (exit) is always accepted
        if (ab == 2'b10 && !full_q) state_d = IN_A;
        else if (ab == 2'b01)       state_d = OUT_B;
      end
      IN_A: begin
        if (ab == 2'b11)      state_d = IN_AB;
        else if (ab == 2'b00) state_d = IDLE;
      end
      IN_AB: begin
        if (ab == 2'b01)      state_d = IN_B;
        else if (ab == 2'b10) state_d = IN_A;
        else if (ab == 2'b00) state_d = IDLE;
      end
      IN_B: begin
        if (ab == 2'b00) begin
          state_d = IDLE;
          up_d    = 1'b1;
        end
      end
      OUT_B: begin
        if (ab == 2'b11)      state_d = OUT_BA;
        else if (ab == 2'b00) state_d = IDLE;
      end
      OUT_BA: begin
        if (ab == 2'b10)      state_d = OUT_A;
        else if (ab == 2'b01) state_d = OUT_B;
        else if (ab == 2'b00) state_d = IDLE;
      end
      OUT_A: begin
        if (ab == 2'b00) begin
          state_d = IDLE;
          dn_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pulses, barrier and full flag; barrier tracks the state it is entering
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      gate_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      gate_q  <= (state_d != IDLE);
      full_q  <= full_d;
    end
  end

  assign count_up   = up_q;
  assign count_down = dn_q;
  assign gate_open  = gate_q;
  assign full       = full_q;

endmodule

// File: tb/tb_park_gate_sequencer.sv
// Bench for park_gate_sequencer: directed scenarios plus random beam patterns,
// every cycle compared against a rule-table model of the gate.
module tb_park_gate_sequencer;

  localparam int CAP = 10;
  localparam int DEB = 4;

  localparam int S_IDLE = 0, S_IN_A = 1, S_IN_AB = 2, S_IN_B = 3;
  localparam int S_OUT_B = 4, S_OUT_BA = 5, S_OUT_A = 6;

  logic       clk, rst, sa, sb;
  logic [3:0] cnt;
  logic       count_up, count_down, gate_open, full;

  park_gate_sequencer #(.CAPACITY(CAP), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .sensor_a(sa), .sensor_b(sb), .count(cnt),
    .count_up(count_up), .count_down(count_down), .gate_open(gate_open), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int ups = 0, dns = 0;

  // ---------------- reference model ----------------
  typedef struct { int from; bit a; bit b; int to; int pulse; } rule_t;
  rule_t rules[$];

  int  mst;
  bit  ca, cb, s1a, s2a, s1b, s2b, mfull;
  bit  wa[$], wb[$];
  bit  m_up, m_dn, m_gate;

  task automatic add_rule(input int f, input bit a, input bit b, input int t, input int p);
    rule_t r;
    r.from = f; r.a = a; r.b = b; r.to = t; r.pulse = p;
    rules.push_back(r);
  endtask

  function automatic bit all_differ(input bit q[$], input bit c);
    if (q.size() < DEB) return 1'b0;
    foreach (q[i]) if (q[i] == c) return 1'b0;
    return 1'b1;
  endfunction

  task automatic mreset();
    mst = S_IDLE; ca = 0; cb = 0; s1a = 0; s2a = 0; s1b = 0; s2b = 0;
    wa.delete(); wb.delete(); mfull = 0; m_up = 0; m_dn = 0; m_gate = 0;
  endtask

  // One rising edge of the model, using the values present at that edge
  task automatic model_edge();
    int nxt, pl;
    bit seen;
    nxt = mst; pl = 0;
    if (!(mst == S_IDLE && ca && !cb && mfull))
      foreach (rules[i])
        if (rules[i].from == mst && rules[i].a == ca && rules[i].b == cb) begin
          nxt = rules[i].to; pl = rules[i].pulse;
        end
    mst = nxt; m_up = (pl == 1); m_dn = (pl == 2); m_gate = (nxt != S_IDLE);
    mfull = (int'(cnt) >= CAP);
    // beam a: a clean value flips once the last DEB synchronized samples all disagree
    seen = s2a; s2a = s1a; s1a = sa;
    wa.push_back(seen); if (wa.size() > DEB) void'(wa.pop_front());
    if (all_differ(wa, ca)) ca = ~ca;
    seen = s2b; s2b = s1b; s1b = sb;
    wb.push_back(seen); if (wb.size() > DEB) void'(wb.pop_front());
    if (all_differ(wb, cb)) cb = ~cb;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check("count_up", count_up, m_up);
    check("count_down", count_down, m_dn);
    check("gate_open", gate_open, m_gate);
    check("full", full, mfull);
    check("no_both", count_up & count_down, 0);
    ups += count_up; dns += count_down;
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    sa = a; sb = b;
    repeat (n) tick();
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_up"}, count_up, 0);
    check({tag, "_dn"}, count_down, 0);
    check({tag, "_gate"}, gate_open, 0);
    check({tag, "_full"}, full, 0);
    mreset();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    add_rule(S_IDLE,   1, 0, S_IN_A,   0);
    add_rule(S_IN_A,   1, 1, S_IN_AB,  0);
    add_rule(S_IN_AB,  0, 1, S_IN_B,   0);
    add_rule(S_IN_B,   0, 0, S_IDLE,   1);
    add_rule(S_IDLE,   0, 1, S_OUT_B,  0);
    add_rule(S_OUT_B,  1, 1, S_OUT_BA, 0);
    add_rule(S_OUT_BA, 1, 0, S_OUT_A,  0);
    add_rule(S_OUT_A,  0, 0, S_IDLE,   2);
    add_rule(S_IN_AB,  1, 0, S_IN_A,   0);
    add_rule(S_OUT_BA, 0, 1, S_OUT_B,  0);
    add_rule(S_IN_A,   0, 0, S_IDLE,   0);
    add_rule(S_IN_AB,  0, 0, S_IDLE,   0);
    add_rule(S_OUT_B,  0, 0, S_IDLE,   0);
    add_rule(S_OUT_BA, 0, 0, S_IDLE,   0);

    // reset state
    rst = 1'b0; sa = 1'b0; sb = 1'b0; cnt = 4'd3;
    mreset();
    repeat (2) tick();
    rst = 1'b1;
    hold(0, 0, 10);

    // entry at count 3
    ups = 0; dns = 0;
    hold(1, 0, 10); check("entry_gate_a", gate_open, 1);
    hold(1, 1, 10); check("entry_gate_ab", gate_open, 1);
    hold(0, 1, 10); check("entry_gate_b", gate_open, 1);
    hold(0, 0, 10);
    check("entry_ups", ups, 1); check("entry_dns", dns, 0); check("entry_gate_end", gate_open, 0);

    // exit at count 5
    cnt = 4'd5; ups = 0; dns = 0;
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    check("exit_dns", dns, 1); check("exit_ups", ups, 0);

    // full lot: entry refused, exit still works
    cnt = 4'd10; ups = 0; dns = 0;
    hold(0, 0, 3); check("full_flag", full, 1);
    hold(1, 0, 20);
    check("full_gate", gate_open, 0); check("full_ups", ups, 0);
    hold(0, 0, 10);
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    check("full_exit_dns", dns, 1); check("full_exit_ups", ups, 0);

    // glitch rejection and latency
    cnt = 4'd3;
    hold(0, 0, 10);
    hold(1, 0, 3);
    hold(0, 0, 12);
    check("glitch_gate", gate_open, 0);
    lat = -1;
    sa = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) sa = 1'b0;
      tick();
      if (lat < 0 && gate_open === 1'b1) lat = i;
    end
    check("latency", lat, 7);
    hold(0, 0, 12);

    // back out of an entry
    ups = 0; dns = 0;
    hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
    check("backout_ups", ups, 0); check("backout_dns", dns, 0); check("backout_gate", gate_open, 0);

    // reset in IN_AB abandons the sequence
    ups = 0; dns = 0;
    hold(1, 0, 10); hold(1, 1, 10);
    check("pre_rst_gate", gate_open, 1);
    pulse_reset("mid_rst");
    hold(1, 0, 10); hold(0, 0, 10);
    check("rst_ups", ups, 0); check("rst_dns", dns, 0);

    // random beam patterns, occupancy values and occasional resets
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 24) == 0) pulse_reset("rnd_rst");
      if ($urandom_range(0, 3) == 0) cnt = 4'($urandom_range(0, 15));
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
    end
    hold(0, 0, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
